// File: rtl/lock_pkg.sv
// Shared state encoding and default parameter constants for the keypad lock.
package lock_pkg;

   typedef enum logic [2:0] {
      LOCKED  = 3'd0,
      ERROR   = 3'd1,
      OPEN    = 3'd2,
      PROG    = 3'd3,
      LOCKOUT = 3'd4
   } lock_state_t;

   localparam int          DEF_DIGIT_W     = 4;
   localparam int          DEF_CODE_LEN    = 4;
   localparam int          DEF_MAX_TRIES   = 3;
   localparam int          DEF_LOCKOUT_CYC = 16;
   localparam logic [15:0] DEF_CODE        = 16'h3012;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter timing the lockout interval; done is high while the count is zero.
module lock_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] cnt_r;

   // Count register: load wins, then decrement, holding at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= W'(0);
      end else if (load) begin
         cnt_r <= load_val;
      end else if (en && (cnt_r != W'(0))) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign done = (cnt_r == W'(0));

endmodule

// File: rtl/lock_system_p.sv
// Parametrised code lock: digit entry, failed-attempt counting, timed lockout.
// Define LOCK_PROG_EN to enable reprogramming of the code while open.
module lock_system_p
   import lock_pkg::*;
#(
   parameter int DIGIT_W     = DEF_DIGIT_W,
   parameter int CODE_LEN    = DEF_CODE_LEN,
   parameter int MAX_TRIES   = DEF_MAX_TRIES,
   parameter int LOCKOUT_CYC = DEF_LOCKOUT_CYC,
   parameter logic [DIGIT_W*CODE_LEN-1:0] DEFAULT_CODE = DEF_CODE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           lock,
   input  logic                           valid,
   input  logic [DIGIT_W-1:0]             pwd,
   input  logic                           prog,
   output logic                           error,
   output logic                           unlck,
   output logic                           locked_out,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

   localparam int CW    = DIGIT_W * CODE_LEN;
   localparam int IDX_W = $clog2(CODE_LEN);
   localparam int TRY_W = $clog2(MAX_TRIES + 1);
   localparam int TMR_W = $clog2(LOCKOUT_CYC + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CODE_LEN - 1);
   localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
   localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCKOUT_CYC - 1);

   // The first-entered digit sits in the most significant slot.
   function automatic logic [DIGIT_W-1:0] code_digit(input logic [CW-1:0] code,
                                                     input logic [IDX_W-1:0] idx);
      int sel;
      sel = (CODE_LEN - 1 - int'(idx)) * DIGIT_W;
      return code[sel +: DIGIT_W];
   endfunction

   lock_state_t        state_r, state_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic               mis_r, mis_s, mis_now_s;
   logic [TRY_W-1:0]   tries_r, tries_s, tries_dec_s;
   logic               error_r, unlck_r, locked_out_r;
   logic               tmr_load_s, tmr_done_s;
   logic [CW-1:0]      code_s;

`ifdef LOCK_PROG_EN
   logic [CW-1:0]      code_r, code_nxt_s, shadow_r, shadow_s, shadow_shift_s;
   assign code_s         = code_r;
   assign shadow_shift_s = {shadow_r[CW-DIGIT_W-1:0], pwd};
`else
   logic               unused_prog_s;
   assign code_s        = DEFAULT_CODE;
   assign unused_prog_s = prog;
`endif

   assign mis_now_s   = mis_r | (pwd != code_digit(code_s, idx_r));
   assign tries_dec_s = (tries_r != TRY_W'(0)) ? (tries_r - TRY_W'(1)) : TRY_W'(0);

   lock_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load_s),
      .load_val (TMR_LOAD),
      .en       (state_r == LOCKOUT),
      .done     (tmr_done_s)
   );

   // Next-state and datapath update; lock takes precedence over valid.
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      mis_s      = mis_r;
      tries_s    = tries_r;
      tmr_load_s = 1'b0;
`ifdef LOCK_PROG_EN
      code_nxt_s = code_r;
      shadow_s   = shadow_r;
`endif
      case (state_r)
         LOCKED, ERROR: begin
            if (lock) begin
               state_s = LOCKED;
               idx_s   = IDX_W'(0);
               mis_s   = 1'b0;
            end else if (valid) begin
               if (idx_r == LAST_IDX) begin
                  idx_s = IDX_W'(0);
                  mis_s = 1'b0;
                  if (!mis_now_s) begin
                     state_s = OPEN;
                     tries_s = TRIES_MAX;
                  end else begin
                     tries_s = tries_dec_s;
                     if (tries_dec_s == TRY_W'(0)) begin
                        state_s    = LOCKOUT;
                        tmr_load_s = 1'b1;
                     end else begin
                        state_s = ERROR;
                     end
                  end
               end else begin
                  state_s = LOCKED;
                  idx_s   = idx_r + IDX_W'(1);
                  mis_s   = mis_now_s;
               end
            end else begin
               state_s = state_r;
            end
         end
         LOCKOUT: begin
            if (tmr_done_s) begin
               state_s = LOCKED;
               tries_s = TRIES_MAX;
            end else begin
               state_s = LOCKOUT;
            end
         end
         OPEN: begin
            if (lock) begin
               state_s = LOCKED;
`ifdef LOCK_PROG_EN
            end else if (valid && prog) begin
               state_s  = PROG;
               shadow_s = shadow_shift_s;
               idx_s    = IDX_W'(1);
`endif
            end else begin
               state_s = OPEN;
            end
         end
`ifdef LOCK_PROG_EN
         PROG: begin
            if (lock) begin
               state_s = LOCKED;
               idx_s   = IDX_W'(0);
            end else if (valid) begin
               shadow_s = shadow_shift_s;
               if (idx_r == LAST_IDX) begin
                  code_nxt_s = shadow_shift_s;
                  state_s    = OPEN;
                  idx_s      = IDX_W'(0);
               end else begin
                  idx_s = idx_r + IDX_W'(1);
               end
            end else begin
               state_s = PROG;
            end
         end
`endif
         default: begin
            state_s = LOCKED;
            idx_s   = IDX_W'(0);
            mis_s   = 1'b0;
         end
      endcase
   end

   // FSM state, entry progress and registered outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= LOCKED;
         idx_r        <= IDX_W'(0);
         mis_r        <= 1'b0;
         tries_r      <= TRIES_MAX;
         error_r      <= 1'b0;
         unlck_r      <= 1'b0;
         locked_out_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         idx_r        <= idx_s;
         mis_r        <= mis_s;
         tries_r      <= tries_s;
         error_r      <= (state_s == ERROR) || (state_s == LOCKOUT);
         unlck_r      <= (state_s == OPEN) || (state_s == PROG);
         locked_out_r <= (state_s == LOCKOUT);
      end
   end

`ifdef LOCK_PROG_EN
   // Active code and the shadow being programmed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_r   <= DEFAULT_CODE;
         shadow_r <= CW'(0);
      end else begin
         code_r   <= code_nxt_s;
         shadow_r <= shadow_s;
      end
   end
`endif

   assign error      = error_r;
   assign unlck      = unlck_r;
   assign locked_out = locked_out_r;
   assign tries_left = tries_r;

endmodule

// File: tb/tb_lock_system_p.sv
// Scoreboard bench for lock_system_p: driver queues expected outputs, monitor compares.
module tb_lock_system_p;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lock;
   logic       valid;
   logic       prog;
   logic [3:0] pwd;
   logic       error;
   logic       unlck;
   logic       locked_out;
   logic [1:0] tries_left;

   // Expected output word: {error, unlck, locked_out, tries_left}
   localparam logic [4:0] LK3 = 5'b000_11;
   localparam logic [4:0] LK2 = 5'b000_10;
   localparam logic [4:0] LK1 = 5'b000_01;
   localparam logic [4:0] ER2 = 5'b100_10;
   localparam logic [4:0] ER1 = 5'b100_01;
   localparam logic [4:0] LO0 = 5'b101_00;
   localparam logic [4:0] OP3 = 5'b010_11;

   logic [4:0] exp_q[$];
   string      name_q[$];
   int         n_vec = 0;
   int         n_bad = 0;

   lock_system_p dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lock       (lock),
      .valid      (valid),
      .pwd        (pwd),
      .prog       (prog),
      .error      (error),
      .unlck      (unlck),
      .locked_out (locked_out),
      .tries_left (tries_left)
   );

   always #5 clk = ~clk;

   // Monitor: after each rising edge, compare the outputs with the oldest expectation.
   always begin
      logic [4:0] ex;
      logic [4:0] got;
      string      nm;
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         ex  = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {error, unlck, locked_out, tries_left};
         n_vec++;
         if (got !== ex) begin
            n_bad++;
            $display("FAIL %s: got err=%b unlck=%b lo=%b tries=%0d, want err=%b unlck=%b lo=%b tries=%0d",
                     nm, got[4], got[3], got[2], got[1:0], ex[4], ex[3], ex[2], ex[1:0]);
         end
      end
   end

   task automatic step(input logic v, input logic [3:0] d, input logic p, input logic l,
                       input logic [4:0] ex, input string nm);
      @(negedge clk);
      valid = v;
      pwd   = d;
      prog  = p;
      lock  = l;
      exp_q.push_back(ex);
      name_q.push_back(nm);
   endtask

   task automatic code4(input logic [15:0] c, input logic p, input logic [4:0] mid,
                        input logic [4:0] fin, input string nm);
      for (int i = 0; i < 4; i++) begin
         logic [3:0] dg;
         dg = c[(3-i)*4 +: 4];
         step(1'b1, dg, p, 1'b0, (i == 3) ? fin : mid, nm);
      end
   endtask

   task automatic relock(input logic [4:0] ex, input string nm);
      step(1'b0, 4'd0, 1'b0, 1'b1, ex, nm);
   endtask

   task automatic reset_pulse(input string nm);
      @(negedge clk);
      rst_n = 1'b0;
      valid = 1'b0;
      lock  = 1'b0;
      prog  = 1'b0;
      pwd   = 4'd0;
      exp_q.push_back(LK3);
      name_q.push_back(nm);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(LK3);
      name_q.push_back(nm);
   endtask

   initial begin
      logic [15:0] good;
      good  = 16'h3012;
      rst_n = 1'b0;
      lock  = 1'b0;
      valid = 1'b0;
      prog  = 1'b0;
      pwd   = 4'd0;

      reset_pulse("reset");

      // Correct code opens.
      code4(16'h3012, 1'b0, LK3, OP3, "open_default");
      step(1'b0, 4'd0, 1'b0, 1'b0, OP3, "open_hold");
      relock(LK3, "relock");

      // Wrong last digit, then recovery from ERROR.
      code4(16'h3015, 1'b0, LK3, ER2, "wrong_last");
      step(1'b0, 4'd0, 1'b0, 1'b0, ER2, "error_hold");
      code4(16'h3012, 1'b0, LK2, OP3, "open_after_error");
      relock(LK3, "relock2");

      // Three failures into lockout; input ignored for the whole interval.
      code4(16'h1111, 1'b0, LK3, ER2, "fail1");
      code4(16'h1111, 1'b0, LK2, ER1, "fail2");
      code4(16'h1111, 1'b0, LK1, LO0, "fail3_lockout");
      for (int k = 0; k < 15; k++) begin
         logic [3:0] dg;
         dg = good[(3 - (k % 4))*4 +: 4];
         step(1'b1, dg, (k == 4), (k == 7), LO0, "lockout_hold");
      end
      step(1'b1, 4'd3, 1'b0, 1'b0, LK3, "lockout_end");
      code4(16'h3012, 1'b0, LK3, OP3, "open_after_lockout");

`ifdef LOCK_PROG_EN
      code4(16'h7719, 1'b1, OP3, OP3, "prog_7719");
      step(1'b0, 4'd0, 1'b0, 1'b0, OP3, "prog_done_open");
      relock(LK3, "relock_prog");
      code4(16'h7719, 1'b0, LK3, OP3, "new_code_opens");
      relock(LK3, "relock3");
      code4(16'h3012, 1'b0, LK3, ER2, "old_code_rejected");
      code4(16'h7719, 1'b0, LK2, OP3, "new_code_after_error");
      step(1'b1, 4'd5, 1'b1, 1'b0, OP3, "prog_partial");
      step(1'b1, 4'd5, 1'b0, 1'b0, OP3, "prog_partial");
      relock(LK3, "prog_abort");
      code4(16'h7719, 1'b0, LK3, OP3, "code_kept_after_abort");
      code4(16'h5555, 1'b1, OP3, OP3, "prog_5555");
      step(1'b0, 4'd0, 1'b0, 1'b0, OP3, "prog5_open");
      reset_pulse("reset_after_prog");
      code4(16'h5555, 1'b0, LK3, ER2, "prog_code_reverted");
      code4(16'h3012, 1'b0, LK2, OP3, "default_after_reset");
      relock(LK3, "relock4");
`else
      code4(16'h7719, 1'b1, OP3, OP3, "prog_ignored");
      relock(LK3, "relock_noprog");
      code4(16'h7719, 1'b0, LK3, ER2, "code_unchanged");
      code4(16'h3012, 1'b0, LK2, OP3, "default_still_opens");
      relock(LK3, "relock4");
`endif

      // Middle-digit mismatch, lock in ERROR, lock beating valid mid-entry.
      code4(16'h3912, 1'b0, LK3, ER2, "wrong_middle");
      relock(LK2, "lock_clears_error");
      step(1'b1, 4'd3, 1'b0, 1'b0, LK2, "partial");
      step(1'b1, 4'd0, 1'b0, 1'b0, LK2, "partial");
      step(1'b1, 4'd1, 1'b0, 1'b1, LK2, "lock_beats_valid");
      code4(16'h3012, 1'b0, LK2, OP3, "open_after_discard");
      relock(LK3, "relock5");

      // Reset mid-entry restores tries and clears the partial entry.
      code4(16'h1111, 1'b0, LK3, ER2, "fail_before_reset");
      step(1'b1, 4'd3, 1'b0, 1'b0, LK2, "mid_entry");
      step(1'b1, 4'd0, 1'b0, 1'b0, LK2, "mid_entry");
      reset_pulse("reset_mid_entry");
      code4(16'h3012, 1'b0, LK3, OP3, "open_after_reset");
      step(1'b0, 4'd0, 1'b0, 1'b0, OP3, "final_idle");

      repeat (3) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
